// File: rtl/dft_sequencer_if.sv
// Sequencer <-> DFT datapath: accumulator/twiddle control, magnitude launch,
// and the per-bin valid/ready output handshake.
interface dft_sequencer_if #(parameter int N_LOG2 = 4) ();
    logic [N_LOG2-1:0] samp_addr;
    logic [N_LOG2-1:0] tw_addr;
    logic              acc_clr;
    logic              acc_en;
    logic              mag_start;
    logic              mag_done;
    logic [N_LOG2-1:0] bin_idx;
    logic              bin_valid;
    logic              bin_ready;
    logic              frame_done;

    modport master (
        output samp_addr, tw_addr, acc_clr, acc_en, mag_start, bin_idx, bin_valid, frame_done,
        input  mag_done, bin_ready
    );

    modport slave (
        input  samp_addr, tw_addr, acc_clr, acc_en, mag_start, bin_idx, bin_valid, frame_done,
        output mag_done, bin_ready
    );
endinterface

// File: rtl/dft_sequencer.sv
// Frame/bin sequencer for the DFT datapath: walks bins k, steps samples n with
// an additive twiddle index, launches magnitude and hands bins downstream.
module dft_sequencer #(
    parameter int N_LOG2 = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic frame_ready,
    output logic busy,
    dft_sequencer_if.master dp
);
    typedef enum logic [2:0] {
        IDLE, WAIT_FRAME, CLEAR, ACCUM, MAG, WAIT_MAG, OUTPUT, DONE
    } state_t;

    localparam logic [N_LOG2-1:0] LAST = '1;

    state_t            state;
    logic [N_LOG2-1:0] k;
    logic [N_LOG2-1:0] n;
    logic [N_LOG2-1:0] tw;

    assign dp.samp_addr = n;
    assign dp.tw_addr   = tw;
    assign dp.bin_idx   = k;

    always_ff @(posedge clk) begin
        if (!rst || (abort && state != IDLE)) begin
            state         <= IDLE;
            k             <= '0;
            n             <= '0;
            tw            <= '0;
            busy          <= 1'b0;
            dp.acc_clr    <= 1'b0;
            dp.acc_en     <= 1'b0;
            dp.mag_start  <= 1'b0;
            dp.bin_valid  <= 1'b0;
            dp.frame_done <= 1'b0;
        end else begin
            dp.acc_clr    <= 1'b0;
            dp.mag_start  <= 1'b0;
            dp.frame_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= WAIT_FRAME;
                    k     <= '0;
                    busy  <= 1'b1;
                end
                WAIT_FRAME: if (frame_ready) begin
                    state      <= CLEAR;
                    dp.acc_clr <= 1'b1;
                end
                CLEAR: begin
                    state     <= ACCUM;
                    n         <= '0;
                    tw        <= '0;
                    dp.acc_en <= 1'b1;
                end
                ACCUM: begin
                    // k*n mod N built by repeated addition; N_LOG2-bit wrap is the modulo
                    n  <= n + 1'b1;
                    tw <= tw + k;
                    if (n == LAST) begin
                        state        <= MAG;
                        dp.acc_en    <= 1'b0;
                        dp.mag_start <= 1'b1;
                    end
                end
                MAG: state <= WAIT_MAG;
                WAIT_MAG: if (dp.mag_done) begin
                    state        <= OUTPUT;
                    dp.bin_valid <= 1'b1;
                end
                OUTPUT: if (dp.bin_ready) begin
                    dp.bin_valid <= 1'b0;
                    if (k == LAST) begin
                        state         <= DONE;
                        dp.frame_done <= 1'b1;
                    end else begin
                        state      <= CLEAR;
                        k          <= k + 1'b1;
                        dp.acc_clr <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    k     <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
